rng_word_arbiter: RTL and testbench
===================================

# rng_word_arbiter

Shares the 16-bit ring-oscillator-seeded random LFSR word among several requesters with round-robin fairness. After each word is handed out, the block enforces a refresh interval of free-running LFSR clocks, so no two grants ever return correlated or overlapping bit content. It sits between the randomized LFSR and its consumers (nonce, key-mask and jitter logic). It optionally monitors the raw metastable bit and stops issuing words if the entropy source appears stuck.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WORD_W, 16, random word width; matches the LFSR output
- REFRESH_CYCLES, 16, LFSR clocks between grants (≥ WORD_W recommended, ≥ 1 required)
- STUCK_LIMIT, 64, consecutive identical metastable samples that count as a health failure
- clk  in  1  system clock; same clock as the LFSR
- rst  in  1  synchronous reset, active-high
- rnd_in  in  WORD_W  current LFSR word
- metastable_in  in  1  raw destabilizer bit; asynchronous to clk
- req  in  NUM_REQ  level requests; a requester holds its bit until it sees its gnt bit
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle wide
- rnd_out  out  WORD_W  word captured at grant; valid while rnd_valid=1
- rnd_valid  out  1  high in the same cycle as gnt
- health_fail  out  1  sticky entropy-failure flag

## Operation
- FSM with 2 states:
  - **FILL**: fill_cnt increments every cycle. When fill_cnt == REFRESH_CYCLES-1, the next state is READY.
  - **READY**: waits for any req bit.
- On a clock edge in READY with req != 0, all of the following register together:
  - gnt = one-hot of the round-robin winner
  - rnd_valid = 1
  - rnd_out = rnd_in
  - state goes to FILL and fill_cnt resets to 0
- Round-robin rule:
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - After a grant, rr_ptr = winner+1 (mod NUM_REQ).
  - With all requesters active, grant order is 0,1,…,NUM_REQ-1,0.
- gnt and rnd_valid clear on the following cycle. rnd_out holds its last value until the next grant.
- Requests raised during FILL wait; nothing is queued beyond the req levels themselves.
- A requester dropping req before it is granted is simply skipped.
- fill_cnt width is $clog2(REFRESH_CYCLES+1).
- metastable_in always passes through a 2-flop synchronizer inside the block.
- Reset values:
  - state = FILL, fill_cnt = 0, rr_ptr = 0
  - gnt = 0, rnd_valid = 0, rnd_out = 0, health_fail = 0
  - synchronizer flops = 0, stuck counter = 0
- Reset mid-operation aborts any pending grant. The full REFRESH_CYCLES interval restarts.

## Timing
- From rst deassertion, the first grant is visible at the earliest in cycle REFRESH_CYCLES+1.
- Under constant request, grants are spaced exactly REFRESH_CYCLES+1 cycles apart.
- Latency from req rise (in READY) to gnt is 1 cycle.
- rnd_out equals rnd_in as sampled on the grant edge. The LFSR word that is visible in the gnt cycle is never reused.
- A new req and a grant to another requester in the same cycle: the new request is evaluated in the next READY.

## Configuration
- **RNG_HEALTH_EN defined:**
  - A repetition counter compares each synchronized metastable sample with the previous one. It increments on equal samples, resets on a change, and saturates at STUCK_LIMIT.
  - On reaching STUCK_LIMIT, health_fail sets and stays set until rst.
  - While health_fail=1, the FSM stays in FILL and no gnt is issued.
- **Undefined:**
  - health_fail is tied to 0 and the counter is absent.
  - metastable_in is still a port, but it is unused.

## Structure
- Shared package rng_pkg holds:
  - the default WORD_W
  - the state enum {FILL, READY}
  - the rr-pointer width function
- Sub-module rr_arbiter (NUM_REQ parameter) is purely combinational: inputs req and rr_ptr, outputs the one-hot winner and its index.
- The health counter stays inline, inside the RNG_HEALTH_EN guard.

## Test plan
- **Reset release, req=4'b0001 held, REFRESH_CYCLES=16:** gnt=0001 and rnd_valid=1 in cycle 17. Next grant at cycle 34.
- **req=4'b1111 held:** gnt sequence is 0001,0010,0100,1000,0001, spaced 17 cycles apart. Each rnd_out equals rnd_in on its grant edge.
- **req=4'b1010 with rr_ptr=2:** gnt=1000, then 0010. Requester 1 drops req before its turn: it is skipped and gnt=1000 repeats.
- **rst asserted 5 cycles into FILL, req held:** gnt and rnd_valid read 0 during the flush. First post-reset grant arrives 17 cycles after rst deasserts.
- **RNG_HEALTH_EN, metastable_in held at 1 for 70 cycles:** health_fail rises after 64 equal synchronized samples. No gnt afterward despite req; a toggling input does not clear it; only rst clears it.
- **RNG_HEALTH_EN, metastable_in toggling every 3 cycles for 1000 cycles:** health_fail stays 0 and grants proceed normally.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and helpers for the random-word arbiter.
package rng_pkg;

    localparam int WORD_W_DEF = 16;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    // Round-robin pointer needs at least one bit even for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after rr_ptr, wrapping.
module rr_arbiter
    import rng_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx
);

    logic [PTR_W-1:0] cand_idx [NUM_REQ];

    // Candidate index for each search offset from the pointer.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            always_comb begin
                int j;
                j = int'(rr_ptr) + gi;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                cand_idx[gi] = PTR_W'(j);
            end
        end
    endgenerate

    // Scan from the farthest offset back so the nearest active one wins.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                winner                = '0;
                winner[cand_idx[k]]   = 1'b1;
                winner_idx            = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/rng_word_arbiter.sv
// Hands out LFSR words round-robin with a refresh gap between grants.
// Optional entropy health monitor enabled by defining RNG_HEALTH_EN.
module rng_word_arbiter
    import rng_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WORD_W         = WORD_W_DEF,
    parameter int REFRESH_CYCLES = 16,
    parameter int STUCK_LIMIT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  rnd_in,
    input  logic               metastable_in,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WORD_W-1:0]  rnd_out,
    output logic               rnd_valid,
    output logic               health_fail
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int CNT_W = $clog2(REFRESH_CYCLES + 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   fill_cnt_reg, fill_cnt_next;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic               rnd_valid_reg;
    logic [WORD_W-1:0]  rnd_out_reg;
    logic               meta_s1_reg, meta_s2_reg;
    logic               health_stop;
    logic               grant_go;
    logic [NUM_REQ-1:0] winner;
    logic [PTR_W-1:0]   winner_idx;
    logic [PTR_W-1:0]   ptr_after;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req),
        .rr_ptr     (rr_ptr_reg),
        .winner     (winner),
        .winner_idx (winner_idx)
    );

    assign ptr_after = (winner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : winner_idx + PTR_W'(1);

    always_comb begin
        state_next    = state_reg;
        fill_cnt_next = fill_cnt_reg;
        grant_go      = 1'b0;
        case (state_reg)
            FILL: begin
                if (fill_cnt_reg == CNT_W'(REFRESH_CYCLES - 1)) begin
                    state_next    = READY;
                    fill_cnt_next = '0;
                end else begin
                    fill_cnt_next = fill_cnt_reg + CNT_W'(1);
                end
            end
            READY: begin
                if (|req) begin
                    grant_go      = 1'b1;
                    state_next    = FILL;
                    fill_cnt_next = '0;
                end
            end
            default: state_next = FILL;
        endcase
        // A failed entropy source parks the FSM in FILL indefinitely.
        if (health_stop) begin
            grant_go   = 1'b0;
            state_next = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FILL;
            fill_cnt_reg  <= '0;
            rr_ptr_reg    <= '0;
            gnt_reg       <= '0;
            rnd_valid_reg <= 1'b0;
            rnd_out_reg   <= '0;
            meta_s1_reg   <= 1'b0;
            meta_s2_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fill_cnt_reg  <= fill_cnt_next;
            gnt_reg       <= grant_go ? winner : '0;
            rnd_valid_reg <= grant_go;
            meta_s1_reg   <= metastable_in;
            meta_s2_reg   <= meta_s1_reg;
            if (grant_go) begin
                rnd_out_reg <= rnd_in;
                rr_ptr_reg  <= ptr_after;
            end
        end
    end

`ifdef RNG_HEALTH_EN
    localparam int SC_W = $clog2(STUCK_LIMIT + 1);

    logic            meta_prev_reg;
    logic [SC_W-1:0] stuck_cnt_reg;
    logic            health_fail_reg;

    // Repetition count of identical synchronized samples, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_prev_reg   <= 1'b0;
            stuck_cnt_reg   <= '0;
            health_fail_reg <= 1'b0;
        end else begin
            meta_prev_reg <= meta_s2_reg;
            if (meta_s2_reg == meta_prev_reg) begin
                if (stuck_cnt_reg != SC_W'(STUCK_LIMIT))
                    stuck_cnt_reg <= stuck_cnt_reg + SC_W'(1);
                if (stuck_cnt_reg >= SC_W'(STUCK_LIMIT - 1))
                    health_fail_reg <= 1'b1;
            end else begin
                stuck_cnt_reg <= '0;
            end
        end
    end

    assign health_stop = health_fail_reg;
    assign health_fail = health_fail_reg;
`else
    logic unused_meta;
    assign unused_meta = meta_s2_reg;
    assign health_stop = 1'b0;
    assign health_fail = 1'b0;
`endif

    assign gnt       = gnt_reg;
    assign rnd_valid = rnd_valid_reg;
    assign rnd_out   = rnd_out_reg;

endmodule

// File: tb/tb_rng_word_arbiter.sv
// Self-checking bench for rng_word_arbiter: vector table, hand sequences, random run vs model.
module tb_rng_word_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int R = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] rnd_in = '0;
    logic         metastable_in = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [W-1:0] rnd_out;
    logic         rnd_valid;
    logic         health_fail;

    rng_word_arbiter #(.NUM_REQ(N), .WORD_W(W), .REFRESH_CYCLES(R), .STUCK_LIMIT(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .rnd_in        (rnd_in),
        .metastable_in (metastable_in),
        .req           (req),
        .gnt           (gnt),
        .rnd_out       (rnd_out),
        .rnd_valid     (rnd_valid),
        .health_fail   (health_fail)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles of mandatory wait, then grant the first requester from ptr.
    int           m_wait = R;
    int           m_ptr  = 0;
    logic [N-1:0] m_gnt  = '0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_rnd  = '0;
    bit           model_on = 1'b1;
    bit           meta_hold = 1'b0;
    int           cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_wait = R; m_ptr = 0; m_gnt = '0; m_valid = 1'b0; m_rnd = '0;
        end else begin
            m_gnt = '0;
            m_valid = 1'b0;
            if (m_wait > 0) begin
                m_wait--;
            end else if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int w;
                    w = (m_ptr + k) % N;
                    if (m_gnt == '0 && req[w]) begin
                        m_gnt[w] = 1'b1;
                        m_ptr = (w + 1) % N;
                    end
                end
                m_valid = 1'b1;
                m_rnd = rnd_in;
                m_wait = R;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (gnt != '0)
            $display("grant gnt=%b word=%h valid=%b t=%0t", gnt, rnd_out, rnd_valid, $time);
        if (model_on) begin
            chk("model_gnt", 32'(gnt), 32'(m_gnt));
            chk("model_valid", 32'(rnd_valid), 32'(m_valid));
            chk("model_rnd_out", 32'(rnd_out), 32'(m_rnd));
            chk("model_health", 32'(health_fail), 32'd0);
        end
        cyc++;
        rnd_in = W'($urandom);
        if (!meta_hold && (cyc % 3 == 0)) metastable_in = ~metastable_in;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int maxc, output logic [N-1:0] g, output int n);
        g = '0;
        n = 0;
        while (n < maxc && g == '0) begin
            tick();
            n++;
            g = gnt;
        end
        if (g == '0) begin
            total++;
            bad++;
            $display("FAIL wait_grant: no gnt within %0d cycles", maxc);
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           cycles;
        logic [N-1:0] exp_gnt;
        logic         exp_valid;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [N-1:0] g;
        int           n;
        int           cnt;

        vecs[0]  = '{4'b0001, 16, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0001, 17, 4'b0001, 1'b1};
        vecs[2]  = '{4'b0001, 33, 4'b0000, 1'b0};
        vecs[3]  = '{4'b0001, 34, 4'b0001, 1'b1};
        vecs[4]  = '{4'b1111, 17, 4'b0001, 1'b1};
        vecs[5]  = '{4'b1111, 34, 4'b0010, 1'b1};
        vecs[6]  = '{4'b1111, 51, 4'b0100, 1'b1};
        vecs[7]  = '{4'b1111, 68, 4'b1000, 1'b1};
        vecs[8]  = '{4'b1111, 85, 4'b0001, 1'b1};
        vecs[9]  = '{4'b1010, 17, 4'b0010, 1'b1};
        vecs[10] = '{4'b1010, 34, 4'b1000, 1'b1};
        vecs[11] = '{4'b1010, 35, 4'b0000, 1'b0};

        // Reset state.
        req = '0;
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_valid", 32'(rnd_valid), 32'd0);
        chk("reset_rnd_out", 32'(rnd_out), 32'd0);
        chk("reset_health", 32'(health_fail), 32'd0);

        for (int i = 0; i < 12; i++) begin
            req = '0;
            do_reset();
            req = vecs[i].req;
            repeat (vecs[i].cycles) tick();
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            chk($sformatf("tbl%0d_valid", i), 32'(rnd_valid), 32'(vecs[i].exp_valid));
        end

        // Pointer at 2 with requesters 1 and 3, then requester 1 withdraws.
        req = '0;
        do_reset();
        req = 4'b1111;
        wait_grant(40, g, n);
        chk("rr_first", 32'(g), 32'b0001);
        wait_grant(40, g, n);
        chk("rr_second", 32'(g), 32'b0010);
        req = 4'b1010;
        wait_grant(40, g, n);
        chk("rr_ptr2_a", 32'(g), 32'b1000);
        wait_grant(40, g, n);
        chk("rr_ptr2_b", 32'(g), 32'b0010);
        chk("rr_spacing", 32'(n), 32'd17);
        wait_grant(40, g, n);
        chk("rr_ptr2_c", 32'(g), 32'b1000);
        req = 4'b1000;
        wait_grant(40, g, n);
        chk("rr_skip_dropped", 32'(g), 32'b1000);

        // Reset five cycles into FILL restarts the whole interval.
        req = '0;
        do_reset();
        req = 4'b0001;
        wait_grant(40, g, n);
        chk("mid_first_lat", 32'(n), 32'd17);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_valid", 32'(rnd_valid), 32'd0);
        tick();
        rst = 1'b0;
        wait_grant(40, g, n);
        chk("mid_post_lat", 32'(n), 32'd17);
        chk("mid_post_gnt", 32'(g), 32'b0001);

        // Randomized requests against the model.
        req = '0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            tick();
        end

`ifdef RNG_HEALTH_EN
        // Stuck source: flag rises, blocks grants, survives toggling, cleared only by reset.
        model_on = 1'b0;
        meta_hold = 1'b1;
        metastable_in = 1'b1;
        req = '0;
        do_reset();
        req = 4'b1111;
        repeat (75) tick();
        chk("hf_set", 32'(health_fail), 32'd1);
        cnt = 0;
        repeat (60) begin
            tick();
            if (gnt != '0) cnt++;
        end
        chk("hf_no_grant", 32'(cnt), 32'd0);
        meta_hold = 1'b0;
        repeat (30) begin
            tick();
            if (gnt != '0) cnt++;
        end
        chk("hf_sticky", 32'(health_fail), 32'd1);
        chk("hf_no_grant_toggle", 32'(cnt), 32'd0);
        model_on = 1'b1;
        do_reset();
        chk("hf_cleared", 32'(health_fail), 32'd0);
        cnt = 0;
        repeat (1000) begin
            tick();
            if (gnt != '0) cnt++;
        end
        chk("hf_toggle_ok", 32'(health_fail), 32'd0);
        chk("hf_toggle_grants", 32'(cnt), 32'(1000 / (R + 1)));
`else
        // Health monitor absent: a stuck input never raises the flag or stops grants.
        meta_hold = 1'b1;
        metastable_in = 1'b1;
        req = '0;
        do_reset();
        req = 4'b1111;
        cnt = 0;
        repeat (70) begin
            tick();
            if (gnt != '0) cnt++;
        end
        chk("nohealth_flag", 32'(health_fail), 32'd0);
        chk("nohealth_grants", 32'(cnt), 32'd4);
        meta_hold = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
